// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: op encodings, control states, divide iteration count.
package hilo_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIV_ITER  = WIDTH_DEF;

  typedef logic [2:0] op_t;

  localparam op_t OP_NONE    = 3'b000;
  localparam op_t OP_MULT_WR = 3'b001;
  localparam op_t OP_DIV     = 3'b010;
  localparam op_t OP_DIVU    = 3'b011;
  localparam op_t OP_MTHI    = 3'b100;
  localparam op_t OP_MTLO    = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } state_e;

endpackage

// File: rtl/hilo_unit_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module div_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q, rem_q, den_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [WIDTH:0]   shifted;
  logic             fits;

  // A zero divisor always "fits", leaving all-ones quotient and the dividend as remainder.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, den_q});
    done_o  = run_q && (cnt_q == CW'(WIDTH - 1));
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      den_q <= divisor_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (abort_i) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      quo_q <= {quo_q[WIDTH-2:0], fits};
      rem_q <= fits ? WIDTH'(shifted - {1'b0, den_q}) : shifted[WIDTH-1:0];
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// MIPS HI/LO register unit: mult capture, mthi/mtlo, iterative div/divu with flush.
// Optional HILO_BYPASS_EN forwards mult_wr/mthi/mtlo write data to hi/lo in the request cycle.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [2*WIDTH-1:0] mult_in,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               flush,
  output logic               busy,
  output logic               div_done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_e           state_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q, a_raw_q;
  logic             neg_quo_q, neg_rem_q, dbz_lat_q;

  logic             accept, is_div, a_neg, b_neg, core_start, core_done;
  logic [WIDTH-1:0] a_mag, b_mag, core_quo, core_rem, fix_quo, fix_rem;

  // Requests are only taken in IDLE; busy mirrors that, so a held request waits.
  always_comb begin
    accept     = op_valid && (state_q == IDLE) && !flush;
    is_div     = (op == OP_DIV) || (op == OP_DIVU);
    a_neg      = (op == OP_DIV) && op_a[WIDTH-1];
    b_neg      = (op == OP_DIV) && op_b[WIDTH-1];
    a_mag      = a_neg ? -op_a : op_a;
    b_mag      = b_neg ? -op_b : op_b;
    core_start = accept && is_div;
    fix_quo    = neg_quo_q ? -core_quo : core_quo;
    fix_rem    = neg_rem_q ? -core_rem : core_rem;
  end

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (core_start),
    .abort_i     (flush),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (core_quo),
    .remainder_o (core_rem),
    .done_o      (core_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_raw_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_lat_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          case (op)
            OP_MULT_WR: begin
              hi_q <= mult_in[2*WIDTH-1:WIDTH];
              lo_q <= mult_in[WIDTH-1:0];
            end
            OP_MTHI: hi_q <= op_a;
            OP_MTLO: lo_q <= op_a;
            OP_DIV, OP_DIVU: begin
              a_raw_q   <= op_a;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              dbz_lat_q <= (op_b == '0);
              state_q   <= DIV;
              busy_q    <= 1'b1;
            end
            default: ;
          endcase
        end
        DIV: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (core_done) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            lo_q   <= dbz_lat_q ? '1 : fix_quo;
            hi_q   <= dbz_lat_q ? a_raw_q : fix_rem;
            done_q <= 1'b1;
            dbz_q  <= dbz_lat_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign div_done    = done_q;
  assign div_by_zero = dbz_q;

`ifdef HILO_BYPASS_EN
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hi = hi_q;
    lo = lo_q;
    if (accept) begin
      case (op)
        OP_MULT_WR: begin
          hi = mult_in[2*WIDTH-1:WIDTH];
          lo = mult_in[WIDTH-1:0];
        end
        OP_MTHI: hi = op_a;
        OP_MTLO: lo = op_a;
        default: ;
      endcase
    end
  end
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule
